// File: rtl/color_select_pipe.sv
// Colour-select pipeline: keeps pixels whose dominant-channel metric beats a threshold, grays the rest.
// Latency: 3 cycles from in_valid to out_valid, fixed, with no stall path.
// Backpressure: none; one pixel is accepted every cycle. Optional highlight counter: COLOR_SELECT_PIXCOUNT_EN.
module color_select_pipe #(
    parameter int             DW        = 8,
    parameter int             MW        = 3*DW+2,
    parameter int             PW        = 24,
    parameter logic [MW-1:0]  R_THR_DEF = 26'h01E43DA,
    parameter logic [MW-1:0]  G_THR_DEF = 26'h00143DA,
    parameter logic [MW-1:0]  B_THR_DEF = '0,
    parameter int             CW        = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] r,
    input  logic [DW-1:0] g,
    input  logic [DW-1:0] b,
    input  logic [PW-1:0] pass_in,
    input  logic          frame_start,
    input  logic [3:0]    clr_sel,
    input  logic          thr_wr,
    input  logic [1:0]    thr_sel,
    input  logic [MW-1:0] thr_data,
    output logic          out_valid,
    output logic [DW-1:0] outR,
    output logic [DW-1:0] outG,
    output logic [DW-1:0] outB,
    output logic [PW-1:0] pass_thru,
    output logic [1:0]    mode,
    output logic [CW-1:0] hl_count
);

    localparam int GW = DW + 9;

    typedef enum logic [1:0] {
        MODE_GREEN = 2'b00,
        MODE_RED   = 2'b01,
        MODE_BLUE  = 2'b10,
        MODE_PASS  = 2'b11
    } mode_e;

    localparam logic [GW-1:0] K_R = GW'(77);
    localparam logic [GW-1:0] K_G = GW'(150);
    localparam logic [GW-1:0] K_B = GW'(29);

    // Mode control
    mode_e pend_q, pend_d, mode_q, mode_d;

    // Thresholds
    logic signed [MW-1:0] r_thr_q, g_thr_q, b_thr_q;

    // Stage 1
    logic                 s1_vld_q;
    logic [DW-1:0]        s1_r_q, s1_g_q, s1_b_q;
    logic signed [DW:0]   s1_drg_q, s1_drb_q, s1_dgb_q;
    mode_e                s1_mode_q;
    logic [PW-1:0]        s1_pass_q;

    // Stage 2
    logic                 s2_vld_q;
    logic [DW-1:0]        s2_r_q, s2_g_q, s2_b_q;
    mode_e                s2_mode_q;
    logic [PW-1:0]        s2_pass_q;
    logic signed [MW-1:0] s2_metric_q;
    logic [DW-1:0]        s2_gs_q;

    // Stage 3 / outputs
    logic                 out_vld_q;
    logic [DW-1:0]        out_r_q, out_g_q, out_b_q;
    logic [PW-1:0]        out_pass_q;

    // Combinational intermediates
    logic signed [MW-1:0] px_r, px_g, px_b, e_rg, e_rb, e_gb;
    logic signed [MW-1:0] rm, gm, bm, metric_d;
    logic [GW-1:0]        gsum;
    logic signed [MW-1:0] thr_cur;
    logic                 hit, keep;

    // Pending request: highest-priority set bit of clr_sel, otherwise hold
    always_comb begin
        pend_d = pend_q;
        if (clr_sel[3])      pend_d = MODE_RED;
        else if (clr_sel[2]) pend_d = MODE_GREEN;
        else if (clr_sel[1]) pend_d = MODE_BLUE;
        else if (clr_sel[0]) pend_d = MODE_PASS;
        mode_d = frame_start ? pend_d : mode_q;
    end

    // Mode registers; a request arriving on the frame_start cycle applies immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q <= MODE_PASS;
            mode_q <= MODE_PASS;
        end else begin
            pend_q <= pend_d;
            mode_q <= mode_d;
        end
    end

    // Threshold register file; select 3 is a no-op
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_thr_q <= $signed(R_THR_DEF);
            g_thr_q <= $signed(G_THR_DEF);
            b_thr_q <= $signed(B_THR_DEF);
        end else if (thr_wr) begin
            case (thr_sel)
                2'd0:    r_thr_q <= $signed(thr_data);
                2'd1:    g_thr_q <= $signed(thr_data);
                2'd2:    b_thr_q <= $signed(thr_data);
                default: ;
            endcase
        end
    end

    // Stage 1: capture pixel, channel differences and the mode in force for this pixel
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld_q  <= 1'b0;
            s1_r_q    <= '0;
            s1_g_q    <= '0;
            s1_b_q    <= '0;
            s1_drg_q  <= '0;
            s1_drb_q  <= '0;
            s1_dgb_q  <= '0;
            s1_mode_q <= MODE_PASS;
            s1_pass_q <= '0;
        end else begin
            s1_vld_q  <= in_valid;
            s1_r_q    <= r;
            s1_g_q    <= g;
            s1_b_q    <= b;
            s1_drg_q  <= $signed({1'b0, r}) - $signed({1'b0, g});
            s1_drb_q  <= $signed({1'b0, r}) - $signed({1'b0, b});
            s1_dgb_q  <= $signed({1'b0, g}) - $signed({1'b0, b});
            s1_mode_q <= mode_q;
            s1_pass_q <= pass_in;
        end
    end

    // Metrics and gray level; (g-r) and (b-r),(b-g) reuse the stored differences negated
    always_comb begin
        px_r = $signed(MW'(s1_r_q));
        px_g = $signed(MW'(s1_g_q));
        px_b = $signed(MW'(s1_b_q));
        e_rg = MW'(s1_drg_q);
        e_rb = MW'(s1_drb_q);
        e_gb = MW'(s1_dgb_q);
        rm   = px_r * e_rg * e_rb;
        gm   = px_g * (-e_rg) * e_gb;
        bm   = px_b * e_rb * e_gb;
        case (s1_mode_q)
            MODE_GREEN: metric_d = gm;
            MODE_BLUE:  metric_d = bm;
            default:    metric_d = rm;
        endcase
        gsum = K_R * GW'(s1_r_q) + K_G * GW'(s1_g_q) + K_B * GW'(s1_b_q);
    end

    // Stage 2: register selected metric and gray level alongside the pixel
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_vld_q    <= 1'b0;
            s2_r_q      <= '0;
            s2_g_q      <= '0;
            s2_b_q      <= '0;
            s2_mode_q   <= MODE_PASS;
            s2_pass_q   <= '0;
            s2_metric_q <= '0;
            s2_gs_q     <= '0;
        end else begin
            s2_vld_q    <= s1_vld_q;
            s2_r_q      <= s1_r_q;
            s2_g_q      <= s1_g_q;
            s2_b_q      <= s1_b_q;
            s2_mode_q   <= s1_mode_q;
            s2_pass_q   <= s1_pass_q;
            s2_metric_q <= metric_d;
            s2_gs_q     <= gsum[8 +: DW];
        end
    end

    // Threshold compare against the live register so a fresh write applies next cycle
    always_comb begin
        case (s2_mode_q)
            MODE_GREEN: thr_cur = g_thr_q;
            MODE_BLUE:  thr_cur = b_thr_q;
            default:    thr_cur = r_thr_q;
        endcase
        hit  = (s2_mode_q != MODE_PASS) && (s2_metric_q > thr_cur);
        keep = (s2_mode_q == MODE_PASS) || hit;
    end

    // Stage 3: output registers hold their last valid pixel while idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_vld_q  <= 1'b0;
            out_r_q    <= '0;
            out_g_q    <= '0;
            out_b_q    <= '0;
            out_pass_q <= '0;
        end else begin
            out_vld_q <= s2_vld_q;
            if (s2_vld_q) begin
                out_r_q    <= keep ? s2_r_q : s2_gs_q;
                out_g_q    <= keep ? s2_g_q : s2_gs_q;
                out_b_q    <= keep ? s2_b_q : s2_gs_q;
                out_pass_q <= s2_pass_q;
            end
        end
    end

`ifdef COLOR_SELECT_PIXCOUNT_EN
    logic [CW-1:0] cnt_q, cnt_step, hl_q;

    // Saturating count of highlighted pixels leaving stage 3
    always_comb begin
        cnt_step = cnt_q;
        if (s2_vld_q && hit && (cnt_q != {CW{1'b1}}))
            cnt_step = cnt_q + 1'b1;
    end

    // Frame boundary snapshots the count, including a pixel counted this same cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            hl_q  <= '0;
        end else if (frame_start) begin
            hl_q  <= cnt_step;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_step;
        end
    end

    assign hl_count = hl_q;
`else
    assign hl_count = '0;
`endif

    assign out_valid = out_vld_q;
    assign outR      = out_r_q;
    assign outG      = out_g_q;
    assign outB      = out_b_q;
    assign pass_thru = out_pass_q;
    assign mode      = mode_q;

endmodule

// File: tb/tb_color_select_pipe.sv
// Directed bench for color_select_pipe: modes, thresholds, latency, hold, counter, reset.
// Expected values are hand-computed from the metric and gray formulas.
// Inputs change 1 time unit after the rising edge and outputs are sampled there too.
module tb_color_select_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  r = '0, g = '0, b = '0;
    logic [23:0] pass_in = '0;
    logic        frame_start = 1'b0;
    logic [3:0]  clr_sel = '0;
    logic        thr_wr = 1'b0;
    logic [1:0]  thr_sel = '0;
    logic [25:0] thr_data = '0;
    logic        out_valid;
    logic [7:0]  outR, outG, outB;
    logic [23:0] pass_thru;
    logic [1:0]  mode;
    logic [19:0] hl_count;

    int checks = 0;
    int failures = 0;

`ifdef COLOR_SELECT_PIXCOUNT_EN
    localparam int EXP_HL = 5;
`else
    localparam int EXP_HL = 0;
`endif

    color_select_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .r(r), .g(g), .b(b),
        .pass_in(pass_in), .frame_start(frame_start), .clr_sel(clr_sel),
        .thr_wr(thr_wr), .thr_sel(thr_sel), .thr_data(thr_data),
        .out_valid(out_valid), .outR(outR), .outG(outG), .outB(outB),
        .pass_thru(pass_thru), .mode(mode), .hl_count(hl_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One pixel through the pipe: out_valid must be low after 2 edges and high with the result after 3
    task automatic send(input string tag, input logic [7:0] pr, input logic [7:0] pg, input logic [7:0] pb,
                        input logic [23:0] ps, input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb);
        in_valid = 1'b1; r = pr; g = pg; b = pb; pass_in = ps;
        step(1);
        in_valid = 1'b0;
        step(1);
        check({tag, "_early"}, 64'(out_valid), 64'(0));
        step(1);
        check({tag, "_vld"}, 64'(out_valid), 64'(1));
        check({tag, "_rgb"}, 64'({outR, outG, outB}), 64'({er, eg, eb}));
        check({tag, "_pass"}, 64'(pass_thru), 64'(ps));
    endtask

    task automatic new_frame(input logic [3:0] c);
        clr_sel = c;
        step(1);
        clr_sel = 4'b0;
        frame_start = 1'b1;
        step(1);
        frame_start = 1'b0;
    endtask

    initial begin
        step(1);
        check("rst_vld", 64'(out_valid), 64'(0));
        check("rst_out", 64'({outR, outG, outB, pass_thru}), 64'(0));
        check("rst_mode", 64'(mode), 64'(3));
        check("rst_hl", 64'(hl_count), 64'(0));
        rst = 1'b1;
        step(1);

        // passthrough after reset
        send("pass", 8'd200, 8'd10, 8'd10, 24'hABCDEF, 8'd200, 8'd10, 8'd10);
        step(1);
        check("hold_vld", 64'(out_valid), 64'(0));
        check("hold_rgb", 64'({outR, outG, outB}), 64'({8'd200, 8'd10, 8'd10}));

        // red mode, default threshold 0x1E43DA
        new_frame(4'b1000);
        check("mode_red", 64'(mode), 64'(1));
        send("red_keep", 8'd200, 8'd10, 8'd10, 24'h000001, 8'd200, 8'd10, 8'd10);   // Rm=7,220,000
        send("red_gray", 8'd100, 8'd100, 8'd100, 24'h000002, 8'd100, 8'd100, 8'd100);
        send("red_neg", 8'd100, 8'd200, 8'd10, 24'h000003, 8'd148, 8'd148, 8'd148); // Rm<0, gs=37990>>8
        send("red_zero", 8'd10, 8'd200, 8'd10, 24'h000004, 8'd121, 8'd121, 8'd121); // Rm=0, gs=31060>>8

        // request without frame_start must not change the active mode
        clr_sel = 4'b0010;
        step(1);
        clr_sel = 4'b0;
        step(2);
        check("mode_pending", 64'(mode), 64'(1));
        frame_start = 1'b1;
        step(1);
        frame_start = 1'b0;
        check("mode_blue", 64'(mode), 64'(2));
        send("blue_keep", 8'd10, 8'd10, 8'd200, 24'h000005, 8'd10, 8'd10, 8'd200);
        send("blue_gray", 8'd200, 8'd10, 8'd10, 24'h000006, 8'd67, 8'd67, 8'd67);   // Bm=0, gs=17190>>8

        // same-cycle request and frame_start; bit2 outranks bit1
        clr_sel = 4'b0110;
        frame_start = 1'b1;
        step(1);
        clr_sel = 4'b0;
        frame_start = 1'b0;
        check("mode_green_now", 64'(mode), 64'(0));

        // Gm=80,000 is below default G threshold 82,906
        send("grn_def", 8'd10, 8'd50, 8'd10, 24'h000007, 8'd33, 8'd33, 8'd33);
        thr_wr = 1'b1; thr_sel = 2'd1; thr_data = 26'd0;
        step(1);
        thr_sel = 2'd3; thr_data = 26'h1FFFFFF;
        step(1);
        thr_wr = 1'b0; thr_sel = 2'd0;
        send("grn_keep", 8'd10, 8'd50, 8'd10, 24'h000008, 8'd10, 8'd50, 8'd10);
        send("grn_flat", 8'd50, 8'd50, 8'd50, 24'h000009, 8'd50, 8'd50, 8'd50);
        send("grn_neg", 8'd200, 8'd100, 8'd10, 24'h00000A, 8'd119, 8'd119, 8'd119);
        send("grn_big", 8'd100, 8'd200, 8'd10, 24'h00000B, 8'd100, 8'd200, 8'd10);

        // counter: clear, stream 5 highlighted + 3 gray back to back, then close the frame
        frame_start = 1'b1;
        step(1);
        frame_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            if (i < 5) begin r = 8'd10; g = 8'(50 + i); b = 8'd10; end
            else       begin r = 8'd50; g = 8'd50;     b = 8'd50; end
            step(1);
        end
        in_valid = 1'b0;
        step(3);
        check("stream_last", 64'({outR, outG, outB}), 64'({8'd50, 8'd50, 8'd50}));
        frame_start = 1'b1;
        step(1);
        frame_start = 1'b0;
        check("hl_frame", 64'(hl_count), 64'(EXP_HL));
        frame_start = 1'b1;
        step(1);
        frame_start = 1'b0;
        check("hl_cleared", 64'(hl_count), 64'(0));

        // reset with two pixels in flight
        in_valid = 1'b1; r = 8'd10; g = 8'd50; b = 8'd10;
        step(1);
        step(1);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("mid_rst_vld", 64'(out_valid), 64'(0));
        check("mid_rst_out", 64'({outR, outG, outB, pass_thru}), 64'(0));
        check("mid_rst_mode", 64'(mode), 64'(3));
        step(1);
        rst = 1'b1;
        step(4);
        check("flushed", 64'(out_valid), 64'(0));
        send("post_rst", 8'd200, 8'd10, 8'd10, 24'h123456, 8'd200, 8'd10, 8'd10);
        new_frame(4'b0100);
        send("thr_reset", 8'd10, 8'd50, 8'd10, 24'h00000C, 8'd33, 8'd33, 8'd33);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
